mini_cpu: RTL and testbench

- Single-cycle, 8-bit accumulator-less execution core: each clock it decodes one 8-bit instruction and acts on two external operands.
- Performs ALU operations (AND/OR/ADD/SUB), loads and stores against a small internal data memory, and jumps by loading an internal program counter.
- Result and status flags are registered outputs consumed by the surrounding datapath or bench.

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/cpu_alu.sv | 58 +++++
 rtl/mini_cpu.sv | 87 ++++++++
 tb/tb_mini_cpu.sv | 123 ++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the mini_cpu core: opcode encodings, default
// widths and a decode helper. Optional opcodes 0x07-0x09 are enabled by
// the CPU_EXT_OPS_EN macro.
package cpu_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;

  typedef logic [7:0] opcode_t;

  localparam opcode_t OP_AND   = 8'h00;
  localparam opcode_t OP_OR    = 8'h01;
  localparam opcode_t OP_ADD   = 8'h02;
  localparam opcode_t OP_SUB   = 8'h03;
  localparam opcode_t OP_LD    = 8'h04;
  localparam opcode_t OP_STORE = 8'h05;
  localparam opcode_t OP_JMP   = 8'h06;
  localparam opcode_t OP_XOR   = 8'h07;
  localparam opcode_t OP_SHL   = 8'h08;
  localparam opcode_t OP_SHR   = 8'h09;

  // True for opcodes that write result and all three flags.
  function automatic logic writes_result(input opcode_t op);
    logic hit;
    hit = (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
          (op == OP_SUB) || (op == OP_LD);
`ifdef CPU_EXT_OPS_EN
    hit = hit || (op == OP_XOR) || (op == OP_SHL) || (op == OP_SHR);
`endif
    return hit;
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for mini_cpu. Produces result and carry/borrow for the
// arithmetic/logic opcodes; other opcodes yield zero. XOR/SHL/SHR exist
// only when CPU_EXT_OPS_EN is defined.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  opcode_t           op,
  output logic [DATA_W-1:0] y,
  output logic              c
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  // Widened add/subtract so bit DATA_W is carry-out or borrow (A < B).
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
  end

  // Opcode select; defaults keep non-ALU opcodes at zero.
  always_comb begin
    y = '0;
    c = 1'b0;
    case (op)
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_ADD: begin
        y = sum[DATA_W-1:0];
        c = sum[DATA_W];
      end
      OP_SUB: begin
        y = diff[DATA_W-1:0];
        c = diff[DATA_W];
      end
`ifdef CPU_EXT_OPS_EN
      OP_XOR: y = a ^ b;
      OP_SHL: begin
        y = {a[DATA_W-2:0], 1'b0};
        c = a[DATA_W-1];
      end
      OP_SHR: begin
        y = {1'b0, a[DATA_W-1:1]};
        c = a[0];
      end
`endif
      default: begin
        y = '0;
        c = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mini_cpu.sv
// mini_cpu: single-cycle 8-bit execution core. Decodes one instruction per
// clock, drives registered result/flags, owns a small data memory and an
// internal program counter. Define CPU_EXT_OPS_EN to enable XOR/SHL/SHR.
module mini_cpu
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  opcode_t           instruction,
  input  logic [DATA_W-1:0] data_in_a,
  input  logic [DATA_W-1:0] data_in_b,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              carry,
  output logic              negative
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] pc;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] alu_y;
  logic              alu_c;
  logic [DATA_W-1:0] next_result;
  logic              next_carry;
  logic              upd;

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .a  (data_in_a),
    .b  (data_in_b),
    .op (instruction),
    .y  (alu_y),
    .c  (alu_c)
  );

  // Decode: pick memory read for LD, ALU output otherwise; upper address bits alias.
  always_comb begin
    addr        = data_in_a[ADDR_W-1:0];
    upd         = writes_result(instruction);
    next_result = alu_y;
    next_carry  = alu_c;
    if (instruction == OP_LD) begin
      next_result = mem[addr];
      next_carry  = 1'b0;
    end
  end

  // Result and flag registers; hold on STORE, JMP and NOP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result   <= '0;
      zero     <= 1'b1;
      carry    <= 1'b0;
      negative <= 1'b0;
    end else if (upd) begin
      result   <= next_result;
      zero     <= (next_result == '0);
      carry    <= next_carry;
      negative <= next_result[DATA_W-1];
    end
  end

  // Data memory: cleared by reset, so a write coinciding with reset is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem <= '{default: '0};
    end else if (instruction == OP_STORE) begin
      mem[addr] <= data_in_b;
    end
  end

  // Program counter: load on JMP, otherwise increment with natural wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= '0;
    end else if (instruction == OP_JMP) begin
      pc <= data_in_a;
    end else begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: tb/tb_mini_cpu.sv
// Directed self-checking bench for mini_cpu.
module tb_mini_cpu;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] instruction;
  logic [7:0] data_in_a;
  logic [7:0] data_in_b;
  logic [7:0] result;
  logic       zero;
  logic       carry;
  logic       negative;

  int n_vec  = 0;
  int n_miss = 0;

  mini_cpu #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .data_in_a   (data_in_a),
    .data_in_b   (data_in_b),
    .result      (result),
    .zero        (zero),
    .carry       (carry),
    .negative    (negative)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] r,
                           input logic z, input logic c, input logic n);
    check({tag, ".result"},   {24'd0, result}, {24'd0, r});
    check({tag, ".zero"},     {31'd0, zero},   {31'd0, z});
    check({tag, ".carry"},    {31'd0, carry},  {31'd0, c});
    check({tag, ".negative"}, {31'd0, negative}, {31'd0, n});
  endtask

  // Drive away from the rising edge, then sample just after it.
  task automatic apply(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    instruction = op;
    data_in_a   = a;
    data_in_b   = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    instruction = 8'hFF;
    data_in_a   = 8'h00;
    data_in_b   = 8'h00;
    #20;
    reset = 1'b0;
    #1;
    check_out("reset", 8'h00, 1'b1, 1'b0, 1'b0);
    check("reset.pc", {24'd0, dut.pc}, 32'h00);

    apply(8'h04, 8'h01, 8'h00); check_out("ld_empty", 8'h00, 1'b1, 1'b0, 1'b0);
    apply(8'h00, 8'hCC, 8'hAA); check_out("and",      8'h88, 1'b0, 1'b0, 1'b1);
    apply(8'h01, 8'hCC, 8'hAA); check_out("or",       8'hEE, 1'b0, 1'b0, 1'b1);
    apply(8'h02, 8'h0F, 8'h01); check_out("add_0f01", 8'h10, 1'b0, 1'b0, 1'b0);
    apply(8'h02, 8'h05, 8'h03); check_out("add_0503", 8'h08, 1'b0, 1'b0, 1'b0);
    apply(8'h03, 8'h0F, 8'h01); check_out("sub_0f01", 8'h0E, 1'b0, 1'b0, 1'b0);
    apply(8'h03, 8'h01, 8'h02); check_out("sub_0102", 8'hFF, 1'b0, 1'b1, 1'b1);
    apply(8'h03, 8'h05, 8'h05); check_out("sub_0505", 8'h00, 1'b1, 1'b0, 1'b0);
    apply(8'h02, 8'hFF, 8'h01); check_out("add_ff01", 8'h00, 1'b1, 1'b1, 1'b0);
    apply(8'h05, 8'h02, 8'hF0); check_out("store",    8'h00, 1'b1, 1'b1, 1'b0);
    apply(8'h04, 8'h02, 8'h00); check_out("ld_2",     8'hF0, 1'b0, 1'b0, 1'b1);
    apply(8'h04, 8'h03, 8'h00); check_out("ld_3",     8'h00, 1'b1, 1'b0, 1'b0);
    apply(8'h04, 8'h12, 8'h00); check_out("ld_alias", 8'hF0, 1'b0, 1'b0, 1'b1);

    apply(8'h06, 8'h40, 8'h00); check_out("jmp", 8'hF0, 1'b0, 1'b0, 1'b1);
    check("jmp.pc", {24'd0, dut.pc}, 32'h40);
    apply(8'hFF, 8'h00, 8'h00); check_out("nop_ff", 8'hF0, 1'b0, 1'b0, 1'b1);
    check("nop.pc", {24'd0, dut.pc}, 32'h41);

`ifdef CPU_EXT_OPS_EN
    apply(8'h07, 8'h81, 8'h0F); check_out("xor", 8'h8E, 1'b0, 1'b0, 1'b1);
    apply(8'h08, 8'h81, 8'h00); check_out("shl", 8'h02, 1'b0, 1'b1, 1'b0);
    apply(8'h09, 8'h81, 8'h00); check_out("shr", 8'h40, 1'b0, 1'b1, 1'b0);
    check("ext.pc", {24'd0, dut.pc}, 32'h44);
`else
    apply(8'h07, 8'h81, 8'h0F); check_out("nop_07", 8'hF0, 1'b0, 1'b0, 1'b1);
    apply(8'h09, 8'h81, 8'h00); check_out("nop_09", 8'hF0, 1'b0, 1'b0, 1'b1);
    check("nop7.pc", {24'd0, dut.pc}, 32'h43);
`endif

    apply(8'h06, 8'hFF, 8'h00); check("jmp_ff.pc", {24'd0, dut.pc}, 32'hFF);
    apply(8'h10, 8'h00, 8'h00); check("wrap.pc",   {24'd0, dut.pc}, 32'h00);

    // Reset in the middle of a STORE: immediate clear, write discarded.
    @(negedge clk);
    instruction = 8'h05;
    data_in_a   = 8'h05;
    data_in_b   = 8'h55;
    #1;
    reset = 1'b1;
    #1;
    check_out("async_rst", 8'h00, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    reset       = 1'b0;
    instruction = 8'hFF;
    check("rst.pc", {24'd0, dut.pc}, 32'h00);
    apply(8'h04, 8'h05, 8'h00); check_out("ld_5_after_rst", 8'h00, 1'b1, 1'b0, 1'b0);
    apply(8'h04, 8'h02, 8'h00); check_out("ld_2_after_rst", 8'h00, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
